// File: rtl/seq_div16by8_pkg.sv
// ---------------------------------------------------------------------------
// seq_div16by8_pkg
// Shared definitions for the iterative restoring divider.
//   - div_state_t : FSM state encoding (IDLE / CALC / ZERO)
//   - DEF_WIDTH_N : default dividend / quotient width
//   - DEF_WIDTH_D : default divisor / remainder width
//   - DIV0_FILL   : fill bit for the divide-by-zero quotient (all ones)
// ---------------------------------------------------------------------------
package seq_div16by8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        ZERO = 2'b10
    } div_state_t;

    localparam int DEF_WIDTH_N = 16;
    localparam int DEF_WIDTH_D = 8;

    // The divide-by-zero quotient is every bit set. It is kept as a single
    // fill bit so that it replicates to whatever quotient width is in use.
    localparam logic DIV0_FILL = 1'b1;

endpackage

// File: rtl/seq_div16by8_sub.sv
// ---------------------------------------------------------------------------
// div_trial_sub
// Ripple-carry subtractor used for the trial subtraction of the divider.
// Computes a - b as a + ~b + 1, so the carry-out is high exactly when the
// subtraction does not borrow.
//   a         in  W  minuend (shifted partial remainder)
//   b         in  W  subtrahend (zero-extended divisor)
//   diff      out W  a - b modulo 2^W
//   no_borrow out 1  carry-out; 1 when a >= b
// ---------------------------------------------------------------------------
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W-1:0] b_inv;
    logic [W:0]   carry;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            assign diff[gi]    = a[gi] ^ b_inv[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b_inv[gi]) |
                                 (a[gi] & carry[gi]) |
                                 (b_inv[gi] & carry[gi]);
        end
    endgenerate

    assign no_borrow = carry[W];

endmodule

// File: rtl/seq_div16by8.sv
// ---------------------------------------------------------------------------
// seq_div16by8
// Iterative restoring divider: one quotient bit per clock.
//   clk         in  1        rising-edge clock
//   rst         in  1        asynchronous active-high reset
//   start       in  1        request pulse, sampled only in IDLE
//   dividend    in  WIDTH_N  unsigned dividend, captured on accept
//   divisor     in  WIDTH_D  unsigned divisor, captured on accept
//   busy        out 1        operation in progress
//   done        out 1        one-cycle completion pulse
//   quotient    out WIDTH_N  result quotient, held until next completion
//   remainder   out WIDTH_D  result remainder, held until next completion
//   div_by_zero out 1        last completed operation had divisor 0
// ---------------------------------------------------------------------------
module seq_div16by8
    import seq_div16by8_pkg::*;
#(
    parameter int WIDTH_N = DEF_WIDTH_N,
    parameter int WIDTH_D = DEF_WIDTH_D,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_N - 1);

    div_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;
    logic [WIDTH_N-1:0] q_reg,     q_next;
    logic [WIDTH_D-1:0] d_reg,     d_next;
    logic [WIDTH_D:0]   r_reg,     r_next;
    logic               busy_reg,  busy_next;
    logic               done_reg,  done_next;
    logic [WIDTH_N-1:0] quot_reg,  quot_next;
    logic [WIDTH_D-1:0] rem_reg,   rem_next;
    logic               dbz_reg,   dbz_next;

    // One restoring step: shift {R,Q} left, trial-subtract D from the top.
    logic [WIDTH_D:0]   shifted;
    logic [WIDTH_D:0]   trial_diff;
    logic               trial_ok;
    logic [WIDTH_D:0]   iter_r;
    logic [WIDTH_N-1:0] iter_q;

    assign shifted = {r_reg[WIDTH_D-1:0], q_reg[WIDTH_N-1]};

    div_trial_sub #(
        .W (WIDTH_D + 1)
    ) u_trial_sub (
        .a         (shifted),
        .b         ({1'b0, d_reg}),
        .diff      (trial_diff),
        .no_borrow (trial_ok)
    );

    assign iter_r = trial_ok ? trial_diff : shifted;
    assign iter_q = {q_reg[WIDTH_N-2:0], trial_ok};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        r_next     = r_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dbz_next   = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    q_next     = dividend;
                    d_next     = divisor;
                    r_next     = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = (divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                r_next   = iter_r;
                q_next   = iter_q;
                cnt_next = cnt_reg + 1'b1;
                // Final step: publish the values this edge produces.
                if (cnt_reg == LAST_CNT) begin
                    quot_next  = iter_q;
                    rem_next   = iter_r[WIDTH_D-1:0];
                    dbz_next   = 1'b0;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            ZERO: begin
                // Q still holds the captured dividend here.
                quot_next  = {WIDTH_N{DIV0_FILL}};
                rem_next   = q_reg[WIDTH_D-1:0];
                dbz_next   = 1'b1;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            r_reg     <= r_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div16by8.sv
// ---------------------------------------------------------------------------
// tb_seq_div16by8
// Directed bench for the sequential divider. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_seq_div16by8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_div16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at the falling edge right after the accepting edge; returns
    // the number of rising edges from the accepting edge to done.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic ez, input int elat);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;          // must not disturb the running operation
        divisor  = ~b;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d",
                 tag, a, b, quotient, remainder, div_by_zero, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] ra;
        logic [7:0]  rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q",    32'(quotient), 32'd0);
        chk("rst_r",    32'(remainder), 32'd0);
        chk("rst_dbz",  32'(div_by_zero), 32'd0);
        rst = 1'b0;

        run_op("norm",   16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 16);
        run_op("maxff",  16'hFFFF,  8'hFF,  16'd257,   8'd0,    1'b0, 16);
        run_op("max1",   16'hFFFF,  8'd1,   16'hFFFF,  8'd0,    1'b0, 16);
        run_op("zero",   16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 1);
        run_op("after0", 16'd200,   8'd9,   16'd22,    8'd2,    1'b0, 16);
        run_op("dvd0",   16'd0,     8'd13,  16'd0,     8'd0,    1'b0, 16);

        // start while busy is ignored
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        lat = 5;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("op busy_ign: 100 / 3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        chk("busy_ign_lat", 32'(lat), 32'd16);
        chk("busy_ign_q",   32'(quotient), 32'd33);
        chk("busy_ign_r",   32'(remainder), 32'd1);

        // start in the done cycle is accepted
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        wait_done(lat);
        $display("op b2b: 50 / 5 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        chk("b2b_lat", 32'(lat), 32'd16);
        chk("b2b_q",   32'(quotient), 32'd10);
        chk("b2b_r",   32'(remainder), 32'd0);
        @(negedge clk);

        // reset mid-operation
        dividend = 16'd60000;
        divisor  = 8'd200;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("op midrst: busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_q",    32'(quotient), 32'd0);
        chk("midrst_r",    32'(remainder), 32'd0);
        chk("midrst_dbz",  32'(div_by_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        run_op("postrst", 16'd60000, 8'd200, 16'd300, 8'd0, 1'b0, 16);

        // random pairs checked by reconstruction
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            @(negedge clk);
            dividend = ra;
            divisor  = rb;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(lat);
            $display("op rand%0d: %0d / %0d -> q=%0d r=%0d", i, ra, rb, quotient, remainder);
            chk("rand_lat", 32'(lat), 32'd16);
            chk("rand_recon", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            chk("rand_rem_lt", 32'(remainder < rb), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
